// File: rtl/mem_access_ctrl_pkg.sv
// Shared memory-stage types: LC-3b memory op encoding plus op-class helpers.
package mem_access_ctrl_pkg;

  typedef enum logic [2:0] {
    MOP_NONE = 3'd0,
    MOP_LDR  = 3'd1,
    MOP_STR  = 3'd2,
    MOP_LDB  = 3'd3,
    MOP_STB  = 3'd4,
    MOP_LDI  = 3'd5,
    MOP_STI  = 3'd6
  } lc3b_mem_op;

  function automatic logic is_load_op(input lc3b_mem_op op);
    return (op == MOP_LDR) || (op == MOP_LDB) || (op == MOP_LDI);
  endfunction

  function automatic logic is_store_op(input lc3b_mem_op op);
    return (op == MOP_STR) || (op == MOP_STB) || (op == MOP_STI);
  endfunction

  function automatic logic is_indirect_op(input lc3b_mem_op op);
    return (op == MOP_LDI) || (op == MOP_STI);
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Execute-side request/response and data-memory port of the memory stage.
// slave = the memory-stage controller, master = its environment (execute + dmem).
interface mem_access_ctrl_if;
  import mem_access_ctrl_pkg::*;

  logic        valid_in;
  lc3b_mem_op  mem_op;
  logic [15:0] address;
  logic [15:0] store_data;
  logic [15:0] dmem_rdata;
  logic        dmem_resp;
  logic        dmem_read;
  logic        dmem_write;
  logic [15:0] dmem_address;
  logic [15:0] dmem_wdata;
  logic [1:0]  dmem_byte_en;
  logic        mem_stall;
  logic [15:0] load_data;
  logic        done;
  logic        timeout_err;

  modport slave (
    input  valid_in, mem_op, address, store_data, dmem_rdata, dmem_resp,
    output dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_byte_en,
           mem_stall, load_data, done, timeout_err
  );

  modport master (
    output valid_in, mem_op, address, store_data, dmem_rdata, dmem_resp,
    input  dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_byte_en,
           mem_stall, load_data, done, timeout_err
  );

endinterface

// File: rtl/mem_access_ctrl_align.sv
// Byte-lane steering: LDB lane select + sign extend, STB replication, lane enables.
// Latency: purely combinational.
// Backpressure: none; follows the latched op/address.
module mem_access_ctrl_align
  import mem_access_ctrl_pkg::*;
(
  input  lc3b_mem_op  op,
  input  logic        addr_lsb,
  input  logic [15:0] rdata,
  input  logic [15:0] store_data,
  output logic [15:0] load_val,
  output logic [15:0] wdata,
  output logic [1:0]  byte_en
);

  logic       is_byte;
  logic [7:0] lane;

  always_comb begin
    is_byte  = (op == MOP_LDB) || (op == MOP_STB);
    lane     = addr_lsb ? rdata[15:8] : rdata[7:0];
    load_val = is_byte ? {{8{lane[7]}}, lane} : rdata;
    // Memory picks the lane via byte_en, so the byte goes out on both halves.
    wdata    = is_byte ? {2{store_data[7:0]}} : store_data;
    byte_en  = is_byte ? (addr_lsb ? 2'b10 : 2'b01) : 2'b11;
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-stage controller: runs dmem handshake (with LDI/STI pointer fetch) for execute.
// Latency: 1 cycle accept + 1 cycle per dmem access minimum, done on the following cycle.
// Backpressure: mem_stall held from accept until done; requests held until dmem_resp/watchdog.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 256
) (
  input logic             clk,
  input logic             rst_n,
  mem_access_ctrl_if.slave bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] IND    = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] DONE_S = 2'd3;

  localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [1:0]      state;
  lc3b_mem_op      op_q;
  logic [15:0]     addr_q;
  logic [15:0]     sd_q;
  logic [WD_W-1:0] wd_cnt;
  logic [15:0]     load_data_q;
  logic            tmo_q;

  logic            start;
  logic            in_ind;
  logic            in_acc;
  logic            wd_expire;
  logic [15:0]     load_val;
  logic [15:0]     wdata_al;
  logic [1:0]      byte_en_al;

  mem_access_ctrl_align u_align (
    .op         (op_q),
    .addr_lsb   (addr_q[0]),
    .rdata      (bus.dmem_rdata),
    .store_data (sd_q),
    .load_val   (load_val),
    .wdata      (wdata_al),
    .byte_en    (byte_en_al)
  );

  assign start     = (state == IDLE) && bus.valid_in && (bus.mem_op != MOP_NONE);
  assign in_ind    = (state == IND);
  assign in_acc    = (state == ACCESS);
  assign wd_expire = (TIMEOUT > 0) && (wd_cnt == WD_W'(TIMEOUT - 1));

  // Request fields come only from latched state, so they stay stable until resp.
  assign bus.dmem_read    = in_ind || (in_acc && is_load_op(op_q));
  assign bus.dmem_write   = in_acc && is_store_op(op_q);
  assign bus.dmem_address = (in_ind || in_acc) ? {addr_q[15:1], 1'b0} : 16'h0000;
  assign bus.dmem_wdata   = bus.dmem_write ? wdata_al : 16'h0000;
  assign bus.dmem_byte_en = in_ind ? 2'b11 : (in_acc ? byte_en_al : 2'b00);
  assign bus.mem_stall    = start || in_ind || in_acc;
  assign bus.load_data    = load_data_q;
  assign bus.done         = (state == DONE_S);
  assign bus.timeout_err  = (state == DONE_S) && tmo_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      op_q        <= MOP_NONE;
      addr_q      <= 16'h0000;
      sd_q        <= 16'h0000;
      wd_cnt      <= '0;
      load_data_q <= 16'h0000;
      tmo_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_q   <= bus.mem_op;
            addr_q <= bus.address;
            sd_q   <= bus.store_data;
            wd_cnt <= '0;
            tmo_q  <= 1'b0;
            state  <= is_indirect_op(bus.mem_op) ? IND : ACCESS;
          end
        end
        IND: begin
          if (bus.dmem_resp) begin
            addr_q <= bus.dmem_rdata;
            wd_cnt <= '0;
            state  <= ACCESS;
          end else if (wd_expire) begin
            tmo_q       <= 1'b1;
            load_data_q <= 16'h0000;
            state       <= DONE_S;
          end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
          end
        end
        ACCESS: begin
          if (bus.dmem_resp) begin
            load_data_q <= is_load_op(op_q) ? load_val : 16'h0000;
            state       <= DONE_S;
          end else if (wd_expire) begin
            tmo_q       <= 1'b1;
            load_data_q <= 16'h0000;
            state       <= DONE_S;
          end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
          end
        end
        default: begin
          // Same instruction is still presented here; it must not restart.
          tmo_q <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: word/byte/indirect ops, reset abort, watchdog.
module tb_mem_access_ctrl;
  import mem_access_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;

  mem_access_ctrl_if bus ();

  mem_access_ctrl #(.TIMEOUT(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_idle();
    bus.valid_in   = 1'b0;
    bus.mem_op     = MOP_NONE;
    bus.address    = 16'h0000;
    bus.store_data = 16'h0000;
    bus.dmem_resp  = 1'b0;
    bus.dmem_rdata = 16'h0000;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, ".read"},   bus.dmem_read,    16'h0);
    check({tag, ".write"},  bus.dmem_write,   16'h0);
    check({tag, ".addr"},   bus.dmem_address, 16'h0);
    check({tag, ".wdata"},  bus.dmem_wdata,   16'h0);
    check({tag, ".be"},     bus.dmem_byte_en, 16'h0);
    check({tag, ".stall"},  bus.mem_stall,    16'h0);
    check({tag, ".done"},   bus.done,         16'h0);
    check({tag, ".tmo"},    bus.timeout_err,  16'h0);
  endtask

  // Single-access op with same-cycle response; leaves the instruction presented in DONE.
  task automatic run_simple(input string tag, input lc3b_mem_op op, input logic [15:0] addr,
                            input logic [15:0] sd, input logic [15:0] rdata,
                            input logic [15:0] exp_addr, input logic [15:0] exp_wdata,
                            input logic [1:0] exp_be, input logic exp_wr,
                            input logic [15:0] exp_load);
    @(negedge clk);
    bus.valid_in = 1'b1; bus.mem_op = op; bus.address = addr; bus.store_data = sd;
    bus.dmem_resp = 1'b0; bus.dmem_rdata = 16'h0000;
    #1;
    check({tag, ".stall0"}, bus.mem_stall, 16'h1);
    check({tag, ".done0"},  bus.done,      16'h0);
    @(negedge clk);
    #1;
    check({tag, ".read"},   bus.dmem_read,    {15'h0, ~exp_wr});
    check({tag, ".write"},  bus.dmem_write,   {15'h0, exp_wr});
    check({tag, ".addr"},   bus.dmem_address, exp_addr);
    check({tag, ".be"},     bus.dmem_byte_en, {14'h0, exp_be});
    check({tag, ".stall1"}, bus.mem_stall,    16'h1);
    if (exp_wr) check({tag, ".wdata"}, bus.dmem_wdata, exp_wdata);
    bus.dmem_resp = 1'b1; bus.dmem_rdata = rdata;
    @(negedge clk);
    bus.dmem_resp = 1'b0;
    #1;
    check({tag, ".done"},   bus.done,        16'h1);
    check({tag, ".stall2"}, bus.mem_stall,   16'h0);
    check({tag, ".tmo"},    bus.timeout_err, 16'h0);
    check({tag, ".load"},   bus.load_data,   exp_load);
    check({tag, ".reqoff"}, {bus.dmem_read, bus.dmem_write}, 16'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    drive_idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check_quiet("reset");
    check("reset.load", bus.load_data, 16'h0000);
    rst_n = 1'b1;

    // Word load, then byte loads in both lanes, then a byte store.
    run_simple("ldr", MOP_LDR, 16'h3001, 16'h0, 16'hBEEF, 16'h3000, 16'h0, 2'b11, 1'b0, 16'hBEEF);
    @(negedge clk);
    drive_idle();
    #1;
    check("ldr.done_pulse", bus.done, 16'h0);
    check("ldr.hold", bus.load_data, 16'hBEEF);
    run_simple("ldb_hi", MOP_LDB, 16'h3001, 16'h0, 16'h80FF, 16'h3000, 16'h0, 2'b10, 1'b0, 16'hFF80);
    run_simple("ldb_lo", MOP_LDB, 16'h3000, 16'h0, 16'h80FF, 16'h3000, 16'h0, 2'b01, 1'b0, 16'hFFFF);
    run_simple("stb", MOP_STB, 16'h2005, 16'h1234, 16'hFFFF, 16'h2004, 16'h3434, 2'b10, 1'b1, 16'h0000);

    // LDI with 3-cycle memory latency on both accesses.
    @(negedge clk);
    bus.valid_in = 1'b1; bus.mem_op = MOP_LDI; bus.address = 16'h4000;
    bus.store_data = 16'h0; bus.dmem_resp = 1'b0;
    #1;
    check("ldi.stall0", bus.mem_stall, 16'h1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check("ldi.ptr_read",  bus.dmem_read,    16'h1);
      check("ldi.ptr_write", bus.dmem_write,   16'h0);
      check("ldi.ptr_addr",  bus.dmem_address, 16'h4000);
      check("ldi.ptr_be",    bus.dmem_byte_en, 16'h3);
      check("ldi.ptr_stall", bus.mem_stall,    16'h1);
      check("ldi.ptr_done",  bus.done,         16'h0);
      if (i == 2) begin bus.dmem_resp = 1'b1; bus.dmem_rdata = 16'h5003; end
    end
    @(negedge clk);
    bus.dmem_resp = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin @(negedge clk); #1; end
      check("ldi.dat_read",  bus.dmem_read,    16'h1);
      check("ldi.dat_addr",  bus.dmem_address, 16'h5002);
      check("ldi.dat_be",    bus.dmem_byte_en, 16'h3);
      check("ldi.dat_stall", bus.mem_stall,    16'h1);
      check("ldi.dat_done",  bus.done,         16'h0);
      if (i == 2) begin bus.dmem_resp = 1'b1; bus.dmem_rdata = 16'h00AA; end
    end
    @(negedge clk);
    bus.dmem_resp = 1'b0;
    #1;
    check("ldi.done",  bus.done,      16'h1);
    check("ldi.load",  bus.load_data, 16'h00AA);
    check("ldi.stall", bus.mem_stall, 16'h0);
    @(negedge clk);
    drive_idle();
    #1;
    check("ldi.single_done", bus.done,      16'h0);
    check("ldi.hold",        bus.load_data, 16'h00AA);

    // Reset while ACCESS is outstanding; a late response must be ignored.
    @(negedge clk);
    bus.valid_in = 1'b1; bus.mem_op = MOP_LDR; bus.address = 16'h7000;
    @(negedge clk);
    #1;
    check("rst.in_access", bus.dmem_read, 16'h1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    drive_idle();
    bus.dmem_resp = 1'b1; bus.dmem_rdata = 16'h1111;
    #1;
    check_quiet("rst");
    check("rst.load", bus.load_data, 16'h0000);
    @(negedge clk);
    bus.dmem_resp = 1'b0;
    #1;
    check("rst.no_done", bus.done,      16'h0);
    check("rst.no_read", bus.dmem_read, 16'h0);
    check("rst.load2",   bus.load_data, 16'h0000);

    // Back-to-back store then load.
    run_simple("b2b_str", MOP_STR, 16'h1001, 16'hABCD, 16'h0, 16'h1000, 16'hABCD, 2'b11, 1'b1, 16'h0000);
    run_simple("b2b_ldr", MOP_LDR, 16'h1002, 16'h0, 16'h5A5A, 16'h1002, 16'h0, 2'b11, 1'b0, 16'h5A5A);

    // Watchdog: no response for TIMEOUT=8 request cycles.
    @(negedge clk);
    bus.valid_in = 1'b1; bus.mem_op = MOP_LDR; bus.address = 16'h6000;
    bus.dmem_resp = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #1;
      check("tmo.read",  bus.dmem_read, 16'h1);
      check("tmo.stall", bus.mem_stall, 16'h1);
      check("tmo.done0", bus.done,      16'h0);
    end
    @(negedge clk);
    #1;
    check("tmo.done",    bus.done,        16'h1);
    check("tmo.err",     bus.timeout_err, 16'h1);
    check("tmo.load",    bus.load_data,   16'h0000);
    check("tmo.dropped", bus.dmem_read,   16'h0);
    check("tmo.stall_n", bus.mem_stall,   16'h0);
    @(negedge clk);
    drive_idle();
    #1;
    check("tmo.done_pulse", bus.done,        16'h0);
    check("tmo.err_pulse",  bus.timeout_err, 16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "bench did not finish");
  end

endmodule
